// File: rtl/adc_so_emulator.sv
// Emulates the serial output of an SPI-style ADC: frames are clocked out on adc_so
// under control of an external reader's adc_cs/adc_clk, sourced from a one-deep holding register.
module adc_so_emulator #(
  parameter int DATA_BITS  = 8,
  parameter int LEAD_ZEROS = 3,
  parameter int FRAME_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 adc_cs,
  input  logic                 adc_clk,
  output logic                 adc_so,
  input  logic [DATA_BITS-1:0] sample_data,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 frame_done,
  output logic [15:0]          frame_count,
  output logic                 underrun,
  input  logic                 clear_flags,
  output logic                 busy
);

  localparam int IDX_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);

  typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

  state_t               state;
  logic                 cs_s1, cs_s2, cs_d;
  logic                 clk_s1, clk_s2, clk_d;
  logic                 cs_fall, cs_rise, clk_fall;
  logic [DATA_BITS-1:0] hold;
  logic                 hold_full;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] load_data;
  logic [IDX_W-1:0]     bit_idx;
  logic [15:0]          count_q;

  // Frame bit k: LEAD_ZEROS zeros, then the sample MSB first, then zero padding.
  function automatic logic bit_at(input logic [IDX_W-1:0] k, input logic [DATA_BITS-1:0] d);
    int ki;
    logic [DATA_BITS-1:0] sh;
    ki = int'(k);
    if (ki < LEAD_ZEROS || ki >= LEAD_ZEROS + DATA_BITS) return 1'b0;
    sh = d << (ki - LEAD_ZEROS);
    return sh[DATA_BITS-1];
  endfunction

  // Pins idle high, so the synchronizers reset to 1 to avoid a false cs edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_s1  <= 1'b1;
      cs_s2  <= 1'b1;
      cs_d   <= 1'b1;
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_d  <= 1'b1;
    end else begin
      cs_s1  <= adc_cs;
      cs_s2  <= cs_s1;
      cs_d   <= cs_s2;
      clk_s1 <= adc_clk;
      clk_s2 <= clk_s1;
      clk_d  <= clk_s2;
    end
  end

  assign cs_fall  = cs_d & ~cs_s2;
  assign cs_rise  = ~cs_d & cs_s2;
  assign clk_fall = clk_d & ~clk_s2;

  // Sample source at frame start: held sample, else same-cycle bypass, else resend.
  always_comb begin
    load_data = shift_reg;
    if (hold_full)         load_data = hold;
    else if (sample_valid) load_data = sample_data;
  end

  // Handshake: a sample transfers on any cycle where sample_valid and sample_ready are both high.
  assign sample_ready = ~hold_full;
  assign busy         = (state == FRAME);
  assign frame_count  = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      adc_so     <= 1'b0;
      frame_done <= 1'b0;
      count_q    <= 16'd0;
      underrun   <= 1'b0;
      hold       <= '0;
      hold_full  <= 1'b0;
      shift_reg  <= '0;
      bit_idx    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (clear_flags) underrun <= 1'b0;
      if (sample_valid && !hold_full && !(state == IDLE && cs_fall)) begin
        hold      <= sample_data;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cs_fall) begin
            shift_reg <= load_data;
            bit_idx   <= '0;
            adc_so    <= bit_at('0, load_data);
            state     <= FRAME;
            if (hold_full)         hold_full <= 1'b0;
            else if (!sample_valid) underrun <= 1'b1;
          end
        end
        FRAME: begin
          // A cs edge masks any coincident sclk edge.
          if (cs_rise) begin
            state  <= IDLE;
            adc_so <= 1'b0;
            if (bit_idx == LAST_IDX) begin
              frame_done <= 1'b1;
              count_q    <= count_q + 16'd1;
            end
          end else if (clk_fall && bit_idx != LAST_IDX) begin
            bit_idx <= bit_idx + 1'b1;
            adc_so  <= bit_at(bit_idx + 1'b1, shift_reg);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/adc_so_emulator.md
ADC_SO_EMULATOR -- requirements
Module: adc_so_emulator

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, sample width.
REQ-002 SHALL have parameter LEAD_ZEROS, default 3, zero bits before the MSB.
REQ-003 SHALL have parameter FRAME_BITS, default 16, bit positions per frame (LEAD_ZEROS+DATA_BITS <= FRAME_BITS).
REQ-004 SHALL have port clk, input, 1, the single system clock (50 MHz).
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port adc_cs, input, 1, chip select from the ADC reader, active low, asynchronous to clk.
REQ-007 SHALL have port adc_clk, input, 1, serial clock from the ADC reader, asynchronous to clk.
REQ-008 SHALL have port adc_so, output, 1, serial data to the ADC reader.
REQ-009 SHALL have port sample_data, input, DATA_BITS, next sample to transmit.
REQ-010 SHALL have port sample_valid, input, 1, sample_data is valid.
REQ-011 SHALL have port sample_ready, output, 1, holding register is empty and accepts a sample.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse at the end of a complete frame.
REQ-013 SHALL have port frame_count, output, 16, count of complete frames.
REQ-014 SHALL have port underrun, output, 1, sticky flag: a frame started with the holding register empty.
REQ-015 SHALL have port clear_flags, input, 1, synchronous clear of underrun.
REQ-016 SHALL have port busy, output, 1, high while a frame is active.

Function
REQ-017 SHALL pass adc_cs and adc_clk through 2-flop synchronizers, then a 1-flop edge detector; an adc_so update SHALL occur exactly 3 clk cycles after the pin edge.
REQ-018 SHALL implement the states IDLE and FRAME; busy SHALL be 1 only in FRAME.
REQ-019 IDLE -> FRAME on a synchronized adc_cs falling edge: load the shift register, set bit_idx=0, and drive the bit at position 0.
REQ-020 In FRAME, each synchronized adc_clk falling edge SHALL increment bit_idx and drive the bit at the new position; bit_idx SHALL saturate at FRAME_BITS-1.
REQ-021 Bit position k SHALL be 0 for k<LEAD_ZEROS, data bit (DATA_BITS-1-(k-LEAD_ZEROS)) for LEAD_ZEROS<=k<LEAD_ZEROS+DATA_BITS, and 0 otherwise; data SHALL be sent MSB first.
REQ-022 adc_clk rising edges SHALL be ignored; adc_clk edges in IDLE SHALL be ignored.
REQ-023 FRAME -> IDLE on a synchronized adc_cs rising edge; adc_so SHALL be 0 in IDLE.
REQ-024 At the adc_cs rising edge, if bit_idx == FRAME_BITS-1: frame_done SHALL pulse for one cycle and frame_count SHALL increment, wrapping from 0xFFFF to 0.
REQ-025 A frame ended with bit_idx < FRAME_BITS-1 SHALL be an abort: no frame_done, no count change, and the sample is consumed.
REQ-026 sample_ready = !hold_full; sample_valid && sample_ready SHALL store sample_data and set hold_full.
REQ-027 At frame start with hold_full=1, the holding register SHALL load into the shift register and hold_full SHALL clear.
REQ-028 At frame start with hold_full=0 and a same-cycle valid write, sample_data SHALL bypass directly into the shift register; hold_full SHALL stay 0 and underrun SHALL not be set.
REQ-029 At frame start with hold_full=0 and no write, the previous shift data SHALL be resent and underrun SHALL set.
REQ-030 If clear_flags and an underrun set occur in the same cycle, set SHALL win.
REQ-031 Simultaneous synchronized adc_cs and adc_clk edges: the cs edge SHALL take priority and the clk edge SHALL be dropped.

Reset
REQ-032 While reset is high: state=IDLE, adc_so=0, busy=0, sample_ready=1 (hold empty), frame_done=0, frame_count=0, underrun=0, shift register=0, bit_idx=0, synchronizers=1 (cs idle high).
REQ-033 Reset asserted mid-frame SHALL abort immediately with no frame_done; after release, the block SHALL wait in IDLE for a new adc_cs falling edge.

Verification
REQ-034 Write 0xA5, then cs low plus 16 sclk falls, then cs high -> adc_so sequence 000_10100101_00000; frame_done pulses once; frame_count=1; sample_ready=1 again.
REQ-035 A frame with no sample written -> resends the previous data; underrun=1; clear_flags -> underrun=0.
REQ-036 cs high after 6 sclk falls -> no frame_done; frame_count unchanged; sample consumed (sample_ready=1).
REQ-037 Preload frame_count=0xFFFF via 65535 frames (or force) and run one frame -> frame_count=0x0000.
REQ-038 Write issued in the same clk cycle as the synchronized cs fall with hold empty -> new data transmitted; underrun stays 0.
REQ-039 Reset pulse at bit 8 -> adc_so=0, busy=0 asynchronously; the next full frame transmits correctly.
